botinfo_queue: RTL and testbench
================================

BOTINFO_QUEUE -- requirements
Module: botinfo_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the snapshot width {LocX, LocY, Sensors, BotInfo}.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all state.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_upd_sysregs, input, 1 bit: Rojobot register-update strobe, level or pulse.
REQ-006 SHALL have port i_botinfo, input, DATA_W bits: live Rojobot register bundle.
REQ-007 SHALL have port i_int_ack, input, 1 bit: core acknowledge; each rising edge pops one entry.
REQ-008 SHALL have port i_clr_overrun, input, 1 bit: synchronous clear of the overrun counter.
REQ-009 SHALL have port o_botinfo, output, DATA_W bits: head-of-queue snapshot.
REQ-010 SHALL have port o_botupdt_sync, output, 1 bit: high while the queue is non-empty.
REQ-011 SHALL have port o_count, output, log2(DEPTH)+1 bits: current occupancy.
REQ-012 SHALL have port o_overrun_cnt, output, 8 bits: number of dropped updates.

Function
REQ-013 SHALL register i_upd_sysregs and i_int_ack each cycle; push_ev = input high AND previous sample low; pop_req likewise for i_int_ack.
REQ-014 SHALL, on push_ev at edge k when not full, write i_botinfo as sampled at edge k into mem[wr_ptr], advance wr_ptr modulo DEPTH, and increment count at edge k.
REQ-015 SHALL set o_botupdt_sync = (count != 0), registered, so it rises at the same edge as the first push: one-cycle latency from the upd rising edge.
REQ-016 SHALL, on pop_req when non-empty, advance rd_ptr modulo DEPTH and decrement count.
REQ-017 SHALL ignore pop_req when empty: no pointer or count change, and no error flag.
REQ-018 SHALL, on push_ev when full and no pop in the same cycle, drop the new snapshot, leave the queue unchanged, and increment o_overrun_cnt, saturating at 255.
REQ-019 SHALL treat simultaneous push_ev and valid pop (non-empty) as pop-then-push: count unchanged, both pointers advance, and no overrun even when full.
REQ-020 SHALL treat simultaneous push_ev and pop_req when empty as push only: count becomes 1.
REQ-021 SHALL drive o_botinfo = mem[rd_ptr] when count != 0, and 0 when empty (show-ahead; no read latency).
REQ-022 SHALL give i_clr_overrun priority over the overrun increment in the same cycle; the result is 0.
REQ-023 SHALL keep count in the range 0..DEPTH; pointers SHALL be log2(DEPTH) bits wide with natural wrap-around.
REQ-024 SHALL hold the queue contents unchanged while i_upd_sysregs stays high; exactly one push occurs per rising edge.

Reset
REQ-025 SHALL, when rstn = 0 at a clk edge, clear wr_ptr, rd_ptr, count and o_overrun_cnt to 0, and force o_botupdt_sync = 0 and o_botinfo = 0.
REQ-026 SHALL set both edge-detect registers to 1 during reset, so an input held high through reset release produces no push or pop.
REQ-027 SHALL have reset asserted mid-operation discard all entries with no partial push or pop; the mem array itself need not be cleared.
REQ-028 SHALL give reset priority over all push, pop and clear events in the same cycle.

Verification
REQ-029 Single update: pulse upd with botinfo=32'h1234_5678 -> next edge: o_botupdt_sync=1, o_count=1, o_botinfo=32'h1234_5678; then an ack rising edge -> o_count=0, sync=0, o_botinfo=0.
REQ-030 Overflow: DEPTH=4, five upd edges with values 1..5 and no ack -> o_count=4, o_overrun_cnt=1; four acks read back 1,2,3,4 in order.
REQ-031 Simultaneous events when full: upd and ack edges on the same cycle with queue holding 1..4 and new value 9 -> o_count=4, overrun unchanged; subsequent reads give 2,3,4,9.
REQ-032 Held levels: upd held high for 20 cycles -> exactly one push; ack held high with an empty queue -> no change; ack held high for 10 cycles with 2 entries -> exactly one pop.
REQ-033 Saturation and clear: 300 overrun events -> o_overrun_cnt=255; i_clr_overrun coincident with a further overrun -> o_overrun_cnt=0.
REQ-034 Reset: rstn low for 1 cycle with 3 entries queued and upd held high across release -> o_count=0, sync=0, and no push after release until upd falls and rises again.

Source files
------------

// File: rtl/botinfo_queue.sv
// Purpose : snapshot queue between the Rojobot register block and the core; each
//           rising edge of i_upd_sysregs captures i_botinfo, each rising edge of
//           i_int_ack releases the head entry.
// Latency : a push is visible on o_count/o_botupdt_sync/o_botinfo at the same edge
//           that samples the update edge (one cycle after the input rises).
// Backpressure: none toward the producer; a push into a full queue with no
//           coincident pop is dropped and counted in o_overrun_cnt (saturating).
//
// Ports:
//   clk, rstn          single clock, synchronous active-low reset
//   i_upd_sysregs      update strobe (level or pulse; only its rising edge pushes)
//   i_botinfo          live register bundle {LocX, LocY, Sensors, BotInfo}
//   i_int_ack          core acknowledge (only its rising edge pops)
//   i_clr_overrun      clears the overrun counter; wins over a same-cycle increment
//   o_botinfo          head-of-queue snapshot, 0 when empty (show-ahead)
//   o_botupdt_sync     high while the queue holds at least one entry
//   o_count            occupancy, 0..DEPTH
//   o_overrun_cnt      dropped-update counter, saturates at 255

module botinfo_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_upd_sysregs,
  input  logic [DATA_W-1:0]         i_botinfo,
  input  logic                      i_int_ack,
  input  logic                      i_clr_overrun,
  output logic [DATA_W-1:0]         o_botinfo,
  output logic                      o_botupdt_sync,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [7:0]                o_overrun_cnt
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  // Previous samples of the strobes, used for rising-edge detection.
  logic              upd_q;
  logic              ack_q;

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              push_ev;
  logic              pop_req;
  logic              empty;
  logic              full;
  logic              do_pop;
  logic              do_push;
  logic              drop;

  assign push_ev = i_upd_sysregs & ~upd_q;
  assign pop_req = i_int_ack & ~ack_q;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);

  // A pop on a full queue frees the slot the same cycle, so the coincident
  // push is accepted (pop-then-push) rather than counted as an overrun.
  // A pop on an empty queue is simply ignored, leaving a push-only cycle.
  assign do_pop  = pop_req & ~empty;
  assign do_push = push_ev & (~full | do_pop);
  assign drop    = push_ev & full & ~do_pop;

  always_comb begin
    count_nxt = count;
    unique case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // Edge detectors preset high so a strobe held across reset release
      // does not look like a fresh rising edge.
      upd_q          <= 1'b1;
      ack_q          <= 1'b1;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      o_botupdt_sync <= 1'b0;
      o_overrun_cnt  <= 8'd0;
    end else begin
      upd_q          <= i_upd_sysregs;
      ack_q          <= i_int_ack;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count          <= count_nxt;
      // Registered from the next-state count so it rises with the first push.
      o_botupdt_sync <= (count_nxt != '0);
      if (i_clr_overrun)
        o_overrun_cnt <= 8'd0;
      else if (drop && (o_overrun_cnt != 8'hFF))
        o_overrun_cnt <= o_overrun_cnt + 8'd1;
    end
  end

  // Storage carries no reset; entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (rstn && do_push)
      mem[wr_ptr] <= i_botinfo;
  end

  assign o_count   = count;
  assign o_botinfo = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_botinfo_queue.sv
module tb_botinfo_queue;

  logic        clk;
  logic        rstn;
  logic        upd;
  logic [31:0] botinfo_in;
  logic        ack;
  logic        clr;
  logic [31:0] botinfo_out;
  logic        sync;
  logic [2:0]  count;
  logic [7:0]  ovr;

  int nvec;
  int nmis;

  botinfo_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_upd_sysregs  (upd),
    .i_botinfo      (botinfo_in),
    .i_int_ack      (ack),
    .i_clr_overrun  (clr),
    .o_botinfo      (botinfo_out),
    .o_botupdt_sync (sync),
    .o_count        (count),
    .o_overrun_cnt  (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] v);
    botinfo_in = v;
    upd = 1'b1;
    cyc(1);
    upd = 1'b0;
    cyc(1);
  endtask

  task automatic pop();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(1);
  endtask

  initial begin
    nvec = 0;
    nmis = 0;
    rstn = 1'b0; upd = 1'b0; ack = 1'b0; clr = 1'b0; botinfo_in = '0;
    cyc(3);
    rstn = 1'b1;
    cyc(1);
    check_vec("rst_count", 32'(count), 32'd0);
    check_vec("rst_sync",  32'(sync),  32'd0);
    check_vec("rst_data",  botinfo_out, 32'd0);
    check_vec("rst_ovr",   32'(ovr),   32'd0);

    // Single update then acknowledge.
    botinfo_in = 32'h1234_5678;
    upd = 1'b1;
    cyc(1);
    check_vec("single_sync",  32'(sync),  32'd1);
    check_vec("single_count", 32'(count), 32'd1);
    check_vec("single_data",  botinfo_out, 32'h1234_5678);
    upd = 1'b0;
    cyc(1);
    ack = 1'b1;
    cyc(1);
    check_vec("single_pop_count", 32'(count), 32'd0);
    check_vec("single_pop_sync",  32'(sync),  32'd0);
    check_vec("single_pop_data",  botinfo_out, 32'd0);
    ack = 1'b0;
    cyc(1);

    // Overflow: five pushes into a 4-deep queue.
    for (int i = 1; i <= 5; i++) push(32'(i));
    check_vec("ovf_count", 32'(count), 32'd4);
    check_vec("ovf_ovr",   32'(ovr),   32'd1);
    for (int i = 1; i <= 4; i++) begin
      check_vec($sformatf("ovf_read%0d", i), botinfo_out, 32'(i));
      pop();
    end
    check_vec("ovf_empty", 32'(count), 32'd0);

    // Push and pop on the same edge with the queue full.
    for (int i = 1; i <= 4; i++) push(32'(i));
    botinfo_in = 32'd9;
    upd = 1'b1;
    ack = 1'b1;
    cyc(1);
    upd = 1'b0;
    ack = 1'b0;
    cyc(1);
    check_vec("simul_count", 32'(count), 32'd4);
    check_vec("simul_ovr",   32'(ovr),   32'd1);
    begin
      logic [31:0] exp_rd [4];
      exp_rd = '{32'd2, 32'd3, 32'd4, 32'd9};
      for (int i = 0; i < 4; i++) begin
        check_vec($sformatf("simul_read%0d", i), botinfo_out, exp_rd[i]);
        pop();
      end
    end

    // Push and pop on the same edge with the queue empty: push only.
    botinfo_in = 32'h77;
    upd = 1'b1;
    ack = 1'b1;
    cyc(1);
    upd = 1'b0;
    ack = 1'b0;
    check_vec("empty_simul_count", 32'(count), 32'd1);
    check_vec("empty_simul_data",  botinfo_out, 32'h77);
    cyc(1);
    pop();

    // Held update level: one push only, contents frozen while held.
    botinfo_in = 32'hAA;
    upd = 1'b1;
    cyc(1);
    botinfo_in = 32'hBB;
    cyc(19);
    check_vec("hold_upd_count", 32'(count), 32'd1);
    check_vec("hold_upd_data",  botinfo_out, 32'hAA);
    upd = 1'b0;
    cyc(1);
    pop();

    // Held ack on an empty queue does nothing, and its level later pops nothing.
    ack = 1'b1;
    cyc(5);
    check_vec("hold_ack_empty", 32'(count), 32'd0);
    push(32'h11);
    push(32'h22);
    check_vec("hold_ack_level_nopop", 32'(count), 32'd2);
    ack = 1'b0;
    cyc(1);
    ack = 1'b1;
    cyc(10);
    check_vec("hold_ack_count", 32'(count), 32'd1);
    check_vec("hold_ack_data",  botinfo_out, 32'h22);
    ack = 1'b0;
    cyc(1);
    pop();

    // Saturation of the overrun counter (starts at 1).
    for (int i = 0; i < 4; i++) push(32'(i + 100));
    for (int i = 0; i < 300; i++) push(32'hDEAD);
    check_vec("sat_ovr",   32'(ovr),   32'd255);
    check_vec("sat_count", 32'(count), 32'd4);
    check_vec("sat_head",  botinfo_out, 32'd100);
    clr = 1'b1;
    botinfo_in = 32'hBEEF;
    upd = 1'b1;
    cyc(1);
    clr = 1'b0;
    upd = 1'b0;
    check_vec("clr_prio_ovr", 32'(ovr), 32'd0);
    cyc(1);
    push(32'hCAFE);
    check_vec("ovr_after_clr", 32'(ovr), 32'd1);

    // Reset mid-operation with 3 entries and update held across release.
    pop();
    check_vec("pre_rst_count", 32'(count), 32'd3);
    upd = 1'b1;
    rstn = 1'b0;
    cyc(1);
    rstn = 1'b1;
    cyc(3);
    check_vec("rst_mid_count", 32'(count), 32'd0);
    check_vec("rst_mid_sync",  32'(sync),  32'd0);
    check_vec("rst_mid_data",  botinfo_out, 32'd0);
    check_vec("rst_mid_ovr",   32'(ovr),   32'd0);
    upd = 1'b0;
    cyc(1);
    check_vec("rst_upd_fall", 32'(count), 32'd0);
    botinfo_in = 32'h5555;
    upd = 1'b1;
    cyc(1);
    check_vec("rst_repush_count", 32'(count), 32'd1);
    check_vec("rst_repush_data",  botinfo_out, 32'h5555);
    upd = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
